// File: rtl/prm_scan_pkg.sv
// Shared types and sizing helpers for the PRM edge-scan sequencer.
// Optional hit counter is enabled with the PRM_SCAN_HITCNT_EN macro.
package prm_scan_pkg;

  localparam int CODE_W = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } scan_state_t;

  // The width is sized to hold MAX_OBS itself, because the counters saturate there.
  function automatic int cnt_width(input int max_obs);
    return $clog2(max_obs + 1);
  endfunction

endpackage

// File: rtl/prm_scan_fold.sv
// Sticky OR-fold of the checker bank's edge masks, one beat per s1 cycle.
// With PRM_SCAN_HITCNT_EN defined it also counts beats with a nonzero mask.
module prm_scan_fold
  import prm_scan_pkg::*;
#(
  parameter int NUM_EDGES = 1024,
  parameter int MAX_OBS   = 256,
  parameter int CNT_W     = cnt_width(MAX_OBS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 s1_i,
  input  logic [NUM_EDGES-1:0] mask_i,
`ifdef PRM_SCAN_HITCNT_EN
  output logic [CNT_W-1:0]     hit_cnt_o,
`endif
  output logic [NUM_EDGES-1:0] blocked_o
);

  logic [NUM_EDGES-1:0] blocked_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blocked_q <= '0;
    end else if (clear_i) begin
      blocked_q <= '0;
    end else if (s1_i) begin
      blocked_q <= blocked_q | mask_i;
    end
  end

  assign blocked_o = blocked_q;

`ifdef PRM_SCAN_HITCNT_EN
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OBS);

  logic [CNT_W-1:0] hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= '0;
    end else if (clear_i) begin
      hit_q <= '0;
    end else if (s1_i && (|mask_i) && (hit_q != MAX_CNT)) begin
      hit_q <= hit_q + 1'b1;
    end
  end

  assign hit_cnt_o = hit_q;
`endif

endmodule

// File: rtl/prm_edge_scan_ctrl.sv
// Scan sequencer: streams obstacle codes into the edge-checker bank and folds its masks.
// Optional hit_cnt output is enabled with the PRM_SCAN_HITCNT_EN macro.
module prm_edge_scan_ctrl
  import prm_scan_pkg::*;
#(
  parameter  int NUM_EDGES = 1024,
  parameter  int MAX_OBS   = 256,
  localparam int CNT_W     = cnt_width(MAX_OBS)
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 start,
  input  logic                 obs_valid,
  input  logic [CODE_W-1:0]    obs_code,
  input  logic                 obs_last,
  output logic                 obs_ready,
  output logic [CODE_W-1:0]    chk_code,
  input  logic [NUM_EDGES-1:0] chk_mask,
  output logic [NUM_EDGES-1:0] blocked,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
`ifdef PRM_SCAN_HITCNT_EN
  output logic [CNT_W-1:0]     hit_cnt,
`endif
  output logic [CNT_W-1:0]     obs_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OBS);

  scan_state_t       state_q;
  logic              ready_q, busy_q, done_q, ovf_q, s1_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q;
  logic              accept, clear;

  // ready_q is high exactly while in SCAN, so it doubles as the accept qualifier.
  assign accept = ready_q & obs_valid;
  assign clear  = (state_q == ST_IDLE) & start;
  assign cnt_d  = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;

  // NOTE: all state updates below use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      s1_q    <= 1'b0;
      cnt_q   <= '0;
      code_q  <= '0;
    end else begin
      done_q <= 1'b0;
      s1_q   <= accept;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (accept) begin
            code_q <= obs_code;
            cnt_q  <= cnt_d;
            if (obs_last || (cnt_d == MAX_CNT)) begin
              ovf_q   <= ~obs_last;
              ready_q <= 1'b0;
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Leave only once the last accepted beat has been folded.
          if (!s1_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  prm_scan_fold #(
    .NUM_EDGES(NUM_EDGES),
    .MAX_OBS  (MAX_OBS),
    .CNT_W    (CNT_W)
  ) u_fold (
    .clk      (CLK),
    .rst_n    (RSTn),
    .clear_i  (clear),
    .s1_i     (s1_q),
    .mask_i   (chk_mask),
`ifdef PRM_SCAN_HITCNT_EN
    .hit_cnt_o(hit_cnt),
`endif
    .blocked_o(blocked)
  );

  assign obs_ready = ready_q;
  assign chk_code  = code_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign obs_cnt   = cnt_q;

endmodule

// File: tb/tb_prm_edge_scan_ctrl.sv
// Self-checking bench for prm_edge_scan_ctrl with a transaction-level reference model.
// Compile with PRM_SCAN_HITCNT_EN defined to also cover hit_cnt.
module tb_prm_edge_scan_ctrl;
  import prm_scan_pkg::*;

  localparam int NE = 8;
  localparam int MO = 4;
  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b1;
  logic          start = 1'b0;
  logic          obs_valid = 1'b0;
  logic          obs_last = 1'b0;
  logic [14:0]   obs_code = '0;
  logic          obs_ready, busy, done, overflow;
  logic [14:0]   chk_code;
  logic [NE-1:0] chk_mask, blocked;
  logic [CW-1:0] obs_cnt;
`ifdef PRM_SCAN_HITCNT_EN
  logic [CW-1:0] hit_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;
  int done_seen = 0;

  prm_edge_scan_ctrl #(.NUM_EDGES(NE), .MAX_OBS(MO)) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .start    (start),
    .obs_valid(obs_valid),
    .obs_code (obs_code),
    .obs_last (obs_last),
    .obs_ready(obs_ready),
    .chk_code (chk_code),
    .chk_mask (chk_mask),
    .blocked  (blocked),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
`ifdef PRM_SCAN_HITCNT_EN
    .hit_cnt  (hit_cnt),
`endif
    .obs_cnt  (obs_cnt)
  );

  always #5 CLK = ~CLK;

  // Behavioural checker bank: maps a code to its edge mask.
  function automatic logic [7:0] bank_f(input logic [14:0] c);
    return c[14:7] ^ {5'b0, c[0], 1'b0, c[0]};
  endfunction
  assign chk_mask = bank_f(chk_code);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (scan transactions on a cycle timeline)
  typedef struct { longint due; logic [7:0] mask; } fold_t;
  fold_t       pend[$];
  longint      cyc = 0;
  longint      m_end = -100;
  bit          m_scan = 0;
  bit          m_ovf = 0;
  int          m_cnt = 0;
  int          m_hit = 0;
  logic [7:0]  m_blk = '0;
  logic [14:0] m_code = '0;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pend.delete();
      m_end = -100; m_scan = 0; m_ovf = 0; m_cnt = 0; m_hit = 0;
      m_blk = '0; m_code = '0;
    end else begin
      cyc++;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        m_blk |= pend[0].mask;
        if (pend[0].mask != 0 && m_hit < MO) m_hit++;
        void'(pend.pop_front());
      end
      if (m_scan) begin
        if (obs_valid) begin
          m_code = obs_code;
          m_cnt++;
          pend.push_back('{due: cyc + 1, mask: bank_f(obs_code)});
          if (obs_last || m_cnt == MO) begin
            m_scan = 0;
            m_ovf  = !obs_last;
            m_end  = cyc;
          end
        end
      end else if (start && cyc >= m_end + 4) begin
        m_scan = 1; m_blk = '0; m_cnt = 0; m_ovf = 0; m_hit = 0;
      end
    end
  end

  always @(negedge CLK) begin
    check("blocked",   32'(blocked),   32'(m_blk));
    check("chk_code",  32'(chk_code),  32'(m_code));
    check("obs_ready", 32'(obs_ready), 32'(m_scan));
    check("busy",      32'(busy),      32'(m_scan || (cyc >= m_end && cyc <= m_end + 1)));
    check("done",      32'(done),      32'(cyc == m_end + 2));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("obs_cnt",   32'(obs_cnt),   32'(m_cnt));
`ifdef PRM_SCAN_HITCNT_EN
    check("hit_cnt",   32'(hit_cnt),   32'(m_hit));
`endif
    if (done) done_seen++;
  end

  // ---------------- stimulus helpers (inputs change 2 time units after posedge)
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [14:0] code, input logic last);
    int n = 0;
    obs_valid = 1'b1; obs_code = code; obs_last = last;
    while (!obs_ready && n < 20) begin tick(); n++; end
    check("send_timeout", 32'(obs_ready), 32'd1);
    tick();
    obs_valid = 1'b0; obs_last = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int n = 0;
    while (!done && n < 20) begin tick(); n++; end
    check("done_seen", 32'(done), 32'd1);
    lat = n + 1;
    tick();
    tick();
  endtask

  initial begin
    int lat;
    int d0;
    #1 RSTn = 1'b0;
    tick(); tick();
    check("rst_blocked", 32'(blocked), 32'h0);
    check("rst_chk_code", 32'(chk_code), 32'h0);
    check("rst_obs_cnt", 32'(obs_cnt), 32'h0);
    RSTn = 1'b1;
    tick();

    // 1. single beat
    pulse_start();
    send(15'h0001, 1'b1);
    wait_done(lat);
    check("t1_latency", 32'(lat), 32'd3);
    check("t1_blocked", 32'(blocked), 32'h05);
    check("t1_cnt", 32'(obs_cnt), 32'd1);

    // 2. three back-to-back beats
    pulse_start();
    send(15'h0080, 1'b0);
    check("t2_ready_mid", 32'(obs_ready), 32'd1);
    send(15'h0800, 1'b0);
    send(15'h0080, 1'b1);
    wait_done(lat);
    check("t2_blocked", 32'(blocked), 32'h11);
    check("t2_cnt", 32'(obs_cnt), 32'd3);
    check("t2_ovf", 32'(overflow), 32'd0);

    // 3. five beats offered, no last
    pulse_start();
    for (int i = 0; i < 4; i++) send(15'h0080 << i, 1'b0);
    check("t3_ready_after4", 32'(obs_ready), 32'd0);
    obs_valid = 1'b1; obs_code = 15'h4000;
    tick();
    obs_valid = 1'b0;
    wait_done(lat);
    check("t3_cnt", 32'(obs_cnt), 32'd4);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_blocked", 32'(blocked), 32'h0f);

    // 4. gapped valid with a stray start during SCAN
    pulse_start();
    send(15'h0100, 1'b0);
    start = 1'b1; tick(); start = 1'b0; tick();
    check("t4_code_hold", 32'(chk_code), 32'h0100);
    check("t4_cnt_mid", 32'(obs_cnt), 32'd1);
    send(15'h1000, 1'b1);
    wait_done(lat);
    check("t4_blocked", 32'(blocked), 32'h22);

    // 5. reset mid-scan
    pulse_start();
    send(15'h0080, 1'b0);
    send(15'h0100, 1'b0);
    d0 = done_seen;
    RSTn = 1'b0;
    #1;
    check("t5_rst_blocked", 32'(blocked), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_cnt", 32'(obs_cnt), 32'd0);
    tick();
    RSTn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t5_no_done", 32'(done_seen), 32'(d0));
    pulse_start();
    send(15'h0200, 1'b1);
    wait_done(lat);
    check("t5_blocked", 32'(blocked), 32'h04);

`ifdef PRM_SCAN_HITCNT_EN
    // 6. hit counter
    pulse_start();
    send(15'h0000, 1'b0);
    send(15'h0100, 1'b0);
    send(15'h0000, 1'b1);
    wait_done(lat);
    check("t6_hit", 32'(hit_cnt), 32'd1);
    check("t6_blocked", 32'(blocked), 32'h02);
`endif

    // random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 2000; i++) begin
      start     = ($urandom_range(0, 5) == 0);
      obs_valid = $urandom_range(0, 1);
      obs_code  = 15'($urandom);
      obs_last  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) RSTn = 1'b0;
      tick();
      RSTn = 1'b1;
    end
    start = 1'b0; obs_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
